// File: rtl/sdram_pingpong_reader.sv
// Streams audio samples out of one SDRAM half while the SD loader refills the other half,
// prefetching words into a small FIFO that is drained one word per audio tick.
module sdram_pingpong_reader #(
  parameter int unsigned HALF_WORDS = 24'h800000,
  parameter logic [24:0] HALF_BASE  = 25'h0800000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk50,
  input  logic                         reset_n,
  input  logic                         start,
  output logic                         fill_half,
  output logic                         playing,
  output logic                         rd_req,
  output logic [24:0]                  rd_address,
  input  logic                         rd_waitrequest,
  input  logic                         rd_valid,
  input  logic [15:0]                  rd_data,
  input  logic                         sample_tick,
  output logic [15:0]                  sample_out,
  output logic                         sample_valid,
  output logic                         underrun,
  output logic [1:0]                   dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]  dbg_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [23:0]   LAST_OFFSET = 24'(HALF_WORDS - 1);
  localparam logic [AW:0]   DEPTH       = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE     = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [23:0]   offset, offset_nx;
  logic          rd_half, half_nx;
  logic          outstanding, outstanding_nx;
  logic [AW:0]   count, count_nx;
  logic          rd_req_nx;
  logic [24:0]   rd_address_nx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   mem [FIFO_DEPTH];

  logic accept, got, push, pop, starve, flush, to_idle, to_play;

  // Read handshake: a request is taken in the cycle where rd_req=1 and rd_waitrequest=0;
  // until then rd_req and rd_address hold. Exactly one rd_valid answers each taken request.
  assign accept  = rd_req && !rd_waitrequest;
  assign got     = rd_valid && outstanding;
  assign push    = got && (state == S_PLAY) && start;
  assign pop     = sample_tick && (state == S_PLAY) && (count != '0);
  assign starve  = sample_tick && (state == S_PLAY) && (count == '0);
  assign flush   = (state == S_PLAY) && (state_nx == S_DRAIN);
  assign to_idle = (state == S_DRAIN) && (state_nx == S_IDLE);
  assign to_play = (state == S_IDLE) && (state_nx == S_PLAY);

  assign dbg_state = state;
  assign dbg_count = count;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_PLAY;
      S_PLAY:  if (!start) state_nx = S_DRAIN;
      // A request still waiting on the bus must be taken and answered before leaving.
      S_DRAIN: if (!outstanding && !rd_req) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    offset_nx      = offset;
    half_nx        = rd_half;
    outstanding_nx = outstanding;
    count_nx       = count;
    if (to_idle) begin
      offset_nx = '0;
      half_nx   = 1'b0;
    end else if (accept) begin
      if (offset == LAST_OFFSET) begin
        offset_nx = '0;
        half_nx   = ~rd_half;
      end else begin
        offset_nx = offset + 24'd1;
      end
    end
    if (accept)
      outstanding_nx = 1'b1;
    else if (got)
      outstanding_nx = 1'b0;
    if (flush)
      count_nx = '0;
    else if (push && !pop)
      count_nx = count + CNT_ONE;
    else if (pop && !push)
      count_nx = count - CNT_ONE;
    rd_req_nx = (rd_req && rd_waitrequest) ||
                ((state_nx == S_PLAY) && !outstanding_nx && (count_nx < DEPTH));
    rd_address_nx = {1'b0, offset_nx} + (half_nx ? HALF_BASE : 25'd0);
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      offset       <= '0;
      rd_half      <= 1'b0;
      outstanding  <= 1'b0;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rd_req       <= 1'b0;
      rd_address   <= '0;
      playing      <= 1'b0;
      fill_half    <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state        <= state_nx;
      offset       <= offset_nx;
      rd_half      <= half_nx;
      outstanding  <= outstanding_nx;
      count        <= count_nx;
      rd_req       <= rd_req_nx;
      rd_address   <= rd_address_nx;
      playing      <= (state_nx == S_PLAY);
      fill_half    <= (state_nx == S_PLAY) && !half_nx;
      sample_valid <= pop;
      if (pop)
        sample_out <= mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (to_play)
        underrun <= 1'b0;
      else if (starve)
        underrun <= 1'b1;
    end
  end

  always_ff @(posedge clk50) begin
    if (push)
      mem[wr_ptr] <= rd_data;
  end

endmodule

// File: tb/tb_sdram_pingpong_reader.sv
// Directed bench for sdram_pingpong_reader: an SDRAM responder, address and sample
// scoreboards fed by the stimulus, and a monitor that pops and compares.
module tb_sdram_pingpong_reader;

  logic        clk50;
  logic        reset_n;
  logic        start;
  logic        fill_half;
  logic        playing;
  logic        rd_req;
  logic [24:0] rd_address;
  logic        rd_waitrequest;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        sample_tick;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        underrun;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_count;

  logic        withhold;
  logic        inject;
  logic [15:0] inject_data;

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] exp_q[$];
  logic [24:0] exp_addr_q[$];

  sdram_pingpong_reader #(
    .HALF_WORDS(8),
    .HALF_BASE (25'h0800000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk50         (clk50),
    .reset_n       (reset_n),
    .start         (start),
    .fill_half     (fill_half),
    .playing       (playing),
    .rd_req        (rd_req),
    .rd_address    (rd_address),
    .rd_waitrequest(rd_waitrequest),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .sample_tick   (sample_tick),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .underrun      (underrun),
    .dbg_state     (dbg_state),
    .dbg_count     (dbg_count)
  );

  // clock / reset
  initial begin
    clk50 = 1'b0;
    forever #10 clk50 = ~clk50;
  end

  function automatic logic [15:0] data_of(input logic [24:0] a);
    return {a[23], a[14:0]};
  endfunction

  function automatic logic [24:0] addr_of(input int idx);
    logic [24:0] low;
    low = 25'(idx % 8);
    return ((idx % 16) < 8) ? low : (25'h0800000 + low);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic do_tick(input logic expect_valid);
    sample_tick = 1'b1;
    @(posedge clk50);
    #1;
    sample_tick = 1'b0;
    @(negedge clk50);
    check("sample_valid_after_tick", {31'd0, sample_valid}, {31'd0, expect_valid});
    @(negedge clk50);
    check("sample_valid_width", {31'd0, sample_valid}, 32'd0);
    @(posedge clk50);
    #1;
  endtask

  // SDRAM responder: zero wait states, data returned the cycle after acceptance
  initial begin
    logic        acc_prev;
    logic [24:0] acc_addr;
    rd_valid = 1'b0;
    rd_data  = '0;
    acc_prev = 1'b0;
    acc_addr = '0;
    forever begin
      @(negedge clk50);
      rd_valid = 1'b0;
      if (inject) begin
        rd_valid = 1'b1;
        rd_data  = inject_data;
      end else if (acc_prev && !withhold) begin
        rd_valid = 1'b1;
        rd_data  = data_of(acc_addr);
      end
      acc_prev = reset_n && rd_req && !rd_waitrequest;
      acc_addr = rd_address;
    end
  end

  // monitor: pops expected addresses on acceptance and expected samples on sample_valid
  initial begin
    forever begin
      @(negedge clk50);
      if (reset_n && rd_req && !rd_waitrequest) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_read: got address %0h, expected none", rd_address);
        end else begin
          check("rd_address_seq", {7'd0, rd_address}, {7'd0, exp_addr_q.pop_front()});
        end
      end
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_sample: got %0h, expected none", sample_out);
        end else begin
          check("sample_out_seq", {16'd0, sample_out}, {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    n_checks++;
    n_fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    start          = 1'b0;
    rd_waitrequest = 1'b0;
    sample_tick    = 1'b0;
    withhold       = 1'b0;
    inject         = 1'b0;
    inject_data    = '0;
    cycles(3);
    check("reset_rd_req",       {31'd0, rd_req},       32'd0);
    check("reset_rd_address",   {7'd0, rd_address},    32'd0);
    check("reset_fill_half",    {31'd0, fill_half},    32'd0);
    check("reset_playing",      {31'd0, playing},      32'd0);
    check("reset_sample_out",   {16'd0, sample_out},   32'd0);
    check("reset_sample_valid", {31'd0, sample_valid}, 32'd0);
    check("reset_underrun",     {31'd0, underrun},     32'd0);
    check("reset_state",        {30'd0, dbg_state},    32'd0);
    reset_n = 1'b1;
    cycles(2);

    // basic play: FIFO fills with addresses 0..3 then stalls
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(addr_of(i));
    start = 1'b1;
    cycles(20);
    check("fill_rd_req_stalled", {31'd0, rd_req},     32'd0);
    check("fill_count_full",     {29'd0, dbg_count},  32'd4);
    check("fill_rd_address",     {7'd0, rd_address},  32'd4);
    check("fill_fill_half",      {31'd0, fill_half},  32'd1);
    check("fill_playing",        {31'd0, playing},    32'd1);
    check("fill_state_play",     {30'd0, dbg_state},  32'd1);

    // ticks drive reads through the half wrap and back to address 0
    for (int k = 1; k <= 13; k++) begin
      exp_addr_q.push_back(addr_of(3 + k));
      exp_q.push_back(data_of(addr_of(k - 1)));
      do_tick(1'b1);
      cycles(4);
      check("fill_half_progress", {31'd0, fill_half},
            ((((4 + k) / 8) % 2) == 0) ? 32'd1 : 32'd0);
    end
    check("wrap_rd_address",   {7'd0, rd_address},        32'd1);
    check("wrap_count",        {29'd0, dbg_count},        32'd4);
    check("wrap_reads_done",   exp_addr_q.size(),         32'd0);

    // waitrequest: request and address hold, offset advances once
    rd_waitrequest = 1'b1;
    exp_q.push_back(data_of(addr_of(13)));
    do_tick(1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk50);
      check("wait_rd_req_hold",     {31'd0, rd_req},    32'd1);
      check("wait_rd_address_hold", {7'd0, rd_address}, 32'd1);
    end
    @(posedge clk50);
    #1;
    exp_addr_q.push_back(25'd1);
    rd_waitrequest = 1'b0;
    cycles(4);
    check("wait_offset_once", {7'd0, rd_address}, 32'd2);
    check("wait_count_full",  {29'd0, dbg_count}, 32'd4);

    // push and pop in the same cycle at count 2
    withhold = 1'b1;
    exp_addr_q.push_back(25'd2);
    exp_q.push_back(data_of(addr_of(14)));
    do_tick(1'b1);
    cycles(3);
    exp_q.push_back(data_of(addr_of(15)));
    do_tick(1'b1);
    cycles(3);
    check("pp_count_before", {29'd0, dbg_count}, 32'd2);
    exp_addr_q.push_back(25'd3);
    exp_q.push_back(data_of(addr_of(16)));
    inject_data = 16'hABCD;
    inject      = 1'b1;
    sample_tick = 1'b1;
    @(posedge clk50);
    #1;
    inject      = 1'b0;
    sample_tick = 1'b0;
    @(negedge clk50);
    check("pp_sample_valid", {31'd0, sample_valid}, 32'd1);
    check("pp_count_same",   {29'd0, dbg_count},    32'd2);
    cycles(3);
    exp_q.push_back(data_of(25'd1));
    do_tick(1'b1);
    cycles(3);
    exp_q.push_back(16'hABCD);
    do_tick(1'b1);
    cycles(3);
    check("pp_count_empty", {29'd0, dbg_count}, 32'd0);

    // underrun: read outstanding but withheld, FIFO empty
    do_tick(1'b0);
    check("underrun_set",       {31'd0, underrun},   32'd1);
    check("underrun_hold_out",  {16'd0, sample_out}, 32'h0000ABCD);
    cycles(3);
    check("underrun_sticky",    {31'd0, underrun},   32'd1);

    // stop with a read outstanding, start again during drain
    start = 1'b0;
    cycles(2);
    check("drain_state",     {30'd0, dbg_state}, 32'd2);
    check("drain_playing",   {31'd0, playing},   32'd0);
    check("drain_fill_half", {31'd0, fill_half}, 32'd0);
    do_tick(1'b0);
    start = 1'b1;
    cycles(3);
    check("drain_waits_for_data", {30'd0, dbg_state}, 32'd2);
    withhold = 1'b0;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(addr_of(i));
    inject_data = 16'h5555;
    inject      = 1'b1;
    @(posedge clk50);
    #1;
    inject = 1'b0;
    @(negedge clk50);
    check("drain_last_cycle", {30'd0, dbg_state}, 32'd2);
    @(negedge clk50);
    check("idle_pass_state",    {30'd0, dbg_state},  32'd0);
    check("idle_rd_address",    {7'd0, rd_address},  32'd0);
    check("idle_keeps_underrun",{31'd0, underrun},   32'd1);
    check("idle_keeps_sample",  {16'd0, sample_out}, 32'h0000ABCD);
    @(negedge clk50);
    check("replay_state",          {30'd0, dbg_state}, 32'd1);
    check("replay_underrun_clear", {31'd0, underrun},  32'd0);
    cycles(12);
    check("replay_count_full", {29'd0, dbg_count}, 32'd4);
    check("replay_reads_done", exp_addr_q.size(),  32'd0);
    exp_addr_q.push_back(25'd4);
    exp_q.push_back(16'h0000);
    do_tick(1'b1);
    cycles(4);
    exp_addr_q.push_back(25'd5);
    exp_q.push_back(16'h0001);
    do_tick(1'b1);
    cycles(4);

    // reset in the middle of a read
    withhold = 1'b1;
    exp_addr_q.push_back(25'd6);
    exp_q.push_back(16'h0002);
    do_tick(1'b1);
    @(negedge clk50);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset_rd_req",     {31'd0, rd_req},     32'd0);
    check("mid_reset_rd_address", {7'd0, rd_address},  32'd0);
    check("mid_reset_fill_half",  {31'd0, fill_half},  32'd0);
    check("mid_reset_playing",    {31'd0, playing},    32'd0);
    check("mid_reset_sample_out", {16'd0, sample_out}, 32'd0);
    check("mid_reset_state",      {30'd0, dbg_state},  32'd0);
    check("mid_reset_count",      {29'd0, dbg_count},  32'd0);
    start = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(1);
    inject_data = 16'h1234;
    inject      = 1'b1;
    @(posedge clk50);
    #1;
    inject = 1'b0;
    cycles(3);
    check("stray_valid_count", {29'd0, dbg_count}, 32'd0);
    check("stray_valid_state", {30'd0, dbg_state}, 32'd0);
    do_tick(1'b0);
    check("idle_tick_no_underrun", {31'd0, underrun}, 32'd0);

    check("samples_all_seen", exp_q.size(),      32'd0);
    check("reads_all_seen",   exp_addr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
